bitpair_pack: RTL and testbench

BITPAIR_PACK -- requirements
Module: bitpair_pack

---
 rtl/bitpair_pack.sv | 179 +++++++++++++++++
 tb/tb_bitpair_pack.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bitpair_pack.sv
// bitpair_pack: packs (sum, carry) bit pairs into WIDTH-bit words and queues
// completed words in a small output FIFO of DEPTH entries.
//   - pair k lands at bits {2k+1, 2k} as {carry, sum}
//   - in_flush emits a partially filled word (unfilled bits zero)
//   - a push into a full FIFO without a same-cycle pop drops the word and sets
//     the sticky ovf flag
// Optional feature: define BITPAIR_PARITY_EN to store per-entry even parity
// and present it on out_parity; otherwise out_parity is tied to 0.
// Handshake: a word leaves the FIFO on a rising edge where out_valid and
// out_ready are both 1; out_data/out_parity hold while out_valid && !out_ready.
// dbg_state exposes the packer FSM (0 = IDLE, 1 = FILL).
module bitpair_pack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic             in_sum,
    input  logic             in_carry,
    input  logic             in_flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity,
    output logic             ovf,
    output logic [3:0]       level,
    output logic             dbg_state
);

    localparam int NPAIR = WIDTH / 2;
    localparam int CW    = $clog2(NPAIR);
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [WIDTH-1:0]  word_w;
    logic              last_pair;
    logic              push;
    logic              pop;
    logic              accept;
    logic              drop;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [3:0]        level_q, level_d;
    logic              ovf_q;

    // Packer: merge the current pair into the word, decide on a push, and
    // compute the next FSM state, pair count and partial word.
    always_comb begin
        word_w    = shreg_q;
        state_d   = state_q;
        count_d   = count_q;
        shreg_d   = shreg_q;
        if (in_valid) begin
            word_w = shreg_q | (WIDTH'({in_carry, in_sum}) << {count_q, 1'b0});
        end
        last_pair = in_valid && (count_q == CW'(NPAIR - 1));
        // A flush only has something to emit once at least one pair is held,
        // either from earlier cycles (FILL) or from this very cycle.
        push      = last_pair || (in_flush && ((state_q == FILL) || in_valid));
        if (push) begin
            state_d = IDLE;
            count_d = '0;
            shreg_d = '0;
        end else if (in_valid) begin
            state_d = FILL;
            count_d = count_q + CW'(1);
            shreg_d = word_w;
        end
    end

    // Packer state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            count_q <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shreg_q <= shreg_d;
        end
    end

    // FIFO control: a full FIFO still accepts a push when the head leaves in
    // the same cycle; otherwise the word is dropped.
    always_comb begin
        pop      = out_valid && out_ready;
        accept   = push && ((level_q != 4'(DEPTH)) || pop);
        drop     = push && !accept;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (accept) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({accept, pop})
            2'b10:   level_d = level_q + 4'd1;
            2'b01:   level_d = level_q - 4'd1;
            default: level_d = level_q;
        endcase
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // FIFO word storage, written on accepted pushes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (accept) begin
            mem_q[wr_ptr_q] <= word_w;
        end
    end

`ifdef BITPAIR_PARITY_EN
    logic par_q [DEPTH];

    // Parity storage alongside each FIFO entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                par_q[i] <= 1'b0;
            end
        end else if (accept) begin
            par_q[wr_ptr_q] <= ^word_w;
        end
    end

    // Parity of the head entry, zero while the FIFO is empty.
    always_comb begin
        out_parity = out_valid ? par_q[rd_ptr_q] : 1'b0;
    end
`else
    // No parity storage in this build.
    always_comb begin
        out_parity = 1'b0;
    end
`endif

    // Output view: head word is shown only while valid, so reset and an empty
    // FIFO both present zeros.
    always_comb begin
        out_valid = (level_q != 4'd0);
        out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
        ovf       = ovf_q;
        level     = level_q;
        dbg_state = (state_q == FILL);
    end

endmodule

// File: tb/tb_bitpair_pack.sv
// Testbench for bitpair_pack: directed scenarios followed by random traffic,
// checked every cycle against a word/queue-level reference model.
module tb_bitpair_pack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int NPAIR = WIDTH / 2;

    logic             clk;
    logic             rstn;
    logic             in_valid;
    logic             in_sum;
    logic             in_carry;
    logic             in_flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_parity;
    logic             ovf;
    logic [3:0]       level;
    logic             dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [WIDTH-1:0] exp_q[$];
    int               m_cnt;
    int               m_val;
    int               m_ovf;

    bitpair_pack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_sum     (in_sum),
        .in_carry   (in_carry),
        .in_flush   (in_flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_parity (out_parity),
        .ovf        (ovf),
        .level      (level),
        .dbg_state  (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cnt = 0;
        m_val = 0;
        m_ovf = 0;
    endtask

    // One clock of the specification-level behaviour.
    task automatic model_step(input int v, input int s, input int c, input int f, input int r);
        bit pop;
        bit do_push;
        pop = (r != 0) && (exp_q.size() > 0);
        if (v != 0) begin
            m_val = m_val + s * (1 << (2 * m_cnt)) + c * (1 << (2 * m_cnt + 1));
            m_cnt = m_cnt + 1;
        end
        do_push = (m_cnt == NPAIR) || ((f != 0) && (m_cnt > 0));
        if (pop) void'(exp_q.pop_front());
        if (do_push) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(WIDTH'(m_val));
            else m_ovf = 1;
            m_cnt = 0;
            m_val = 0;
        end
    endtask

    task automatic check_all();
        int exp_par;
        logic [WIDTH-1:0] head;
        head = (exp_q.size() > 0) ? exp_q[0] : '0;
`ifdef BITPAIR_PARITY_EN
        exp_par = $countones(head) % 2;
`else
        exp_par = 0;
`endif
        chk("out_valid",  out_valid,  (exp_q.size() > 0) ? 1 : 0);
        chk("out_data",   out_data,   head);
        chk("out_parity", out_parity, exp_par);
        chk("level",      level,      exp_q.size());
        chk("ovf",        ovf,        m_ovf);
        chk("state",      dbg_state,  (m_cnt > 0) ? 1 : 0);
    endtask

    // Drive one cycle's inputs just after a falling edge, step the model,
    // and check the outputs on the next falling edge.
    task automatic cycle(input int v, input int s, input int c, input int f, input int r);
        in_valid  = (v != 0);
        in_sum    = (s != 0);
        in_carry  = (c != 0);
        in_flush  = (f != 0);
        out_ready = (r != 0);
        model_step(v, s, c, f, r);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset: outputs checked before any clock edge occurs.
    task automatic do_reset();
        in_valid  = 1'b0;
        in_sum    = 1'b0;
        in_carry  = 1'b0;
        in_flush  = 1'b0;
        out_ready = 1'b0;
        rstn      = 1'b0;
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    function automatic int rbit();
        return int'($urandom_range(0, 1));
    endfunction

    initial begin
        do_reset();

        // Scenario 1: (1,0),(0,1),(1,1),(0,0) -> 8'h39
        cycle(1, 1, 0, 0, 1);
        cycle(1, 0, 1, 0, 1);
        cycle(1, 1, 1, 0, 1);
        cycle(1, 0, 0, 0, 1);
        chk("s1_word", out_data, 32'h39);
        cycle(0, 0, 0, 0, 1);

        // Scenario 2: (1,1),(1,0) then flush -> 8'h07, back to IDLE
        cycle(1, 1, 1, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        chk("s2_word", out_data, 32'h07);
        chk("s2_idle", dbg_state, 0);
        cycle(0, 0, 0, 0, 1);

        // Flush in IDLE without a pair is a no-op; flush with a single pair emits it
        cycle(0, 0, 0, 1, 0);
        chk("idle_flush_level", level, 0);
        cycle(1, 1, 1, 1, 0);
        chk("flush_with_pair", out_data, 32'h03);
        cycle(0, 0, 0, 0, 1);

        // Scenario 3: three full words with the consumer stalled
        for (int w = 0; w < 3; w++)
            for (int p = 0; p < NPAIR; p++) cycle(1, rbit(), rbit(), 0, 0);
        chk("s3_level", level, 2);
        chk("s3_ovf", ovf, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        chk("s3_drained", level, 0);

        // Scenario 4: full FIFO, completing pair coincides with a pop
        do_reset();
        for (int w = 0; w < 2; w++)
            for (int p = 0; p < NPAIR; p++) cycle(1, rbit(), rbit(), 0, 0);
        for (int p = 0; p < NPAIR - 1; p++) cycle(1, rbit(), rbit(), 0, 0);
        cycle(1, rbit(), rbit(), 0, 1);
        chk("s4_level", level, 2);
        chk("s4_ovf", ovf, 0);

        // Scenario 5: reset mid-word with one word queued
        do_reset();
        for (int p = 0; p < NPAIR; p++) cycle(1, rbit(), rbit(), 0, 0);
        cycle(1, 1, 1, 0, 0);
        cycle(1, 1, 1, 0, 0);
        chk("s5_pre_level", level, 1);
        do_reset();
        chk("s5_rst_data", out_data, 0);
        chk("s5_rst_valid", out_valid, 0);
        cycle(1, 0, 1, 0, 1);
        cycle(1, 1, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 1, 1, 0, 1);
        chk("s5_fresh_word", out_data, 32'hC6);
        cycle(0, 0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0) ? 1 : 0, rbit(), rbit(),
                  ($urandom_range(0, 7) == 0) ? 1 : 0,
                  ($urandom_range(0, 2) != 0) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
